// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN operand stack: default sizes, count width and FSM states.
package rpn_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

endpackage

// File: rtl/rpn_stack_regfile.sv
// DEPTH x WIDTH stack storage: one write port, two combinational read ports, plus an
// in-place exchange of the two addressed read entries.
module rpn_stack_regfile
  import rpn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     swap,
  input  logic [$clog2(DEPTH)-1:0] top_addr,
  input  logic [$clog2(DEPTH)-1:0] sec_addr,
  output logic [WIDTH-1:0]         top_data,
  output logic [WIDTH-1:0]         sec_data
);

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];

  assign top_data = entry_q[top_addr];
  assign sec_data = entry_q[sec_addr];

  always_comb begin
    entry_d = entry_q;
    if (swap) begin
      entry_d[top_addr] = entry_q[sec_addr];
      entry_d[sec_addr] = entry_q[top_addr];
    end else if (we) begin
      entry_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: rtl/rpn_operand_stack.sv
// Operand stack and sequencer feeding an external combinational subtractor.
// Optional macro RPN_OPERAND_STACK_SWAP_EN adds a 'swap' strobe exchanging the top two entries.
module rpn_operand_stack
  import rpn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   exec,
`ifdef RPN_OPERAND_STACK_SWAP_EN
  input  logic                   swap,
`endif
  input  logic                   clear_err,
  input  logic [WIDTH-1:0]       alu_diff,
  input  logic                   alu_bo,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  output logic                   op_bi,
  output logic [WIDTH-1:0]       top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   borrow_flag,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] TWO  = CW'(2);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             set_ovf, set_unf;

  logic             we, swap_do, swap_req, has_two;
  logic [AW-1:0]    waddr, top_addr, sec_addr;
  logic [WIDTH-1:0] wdata, top_rd, sec_rd;

`ifdef RPN_OPERAND_STACK_SWAP_EN
  assign swap_req = swap;
`else
  assign swap_req = 1'b0;
`endif

  // DEPTH is a power of two, so modular AW-bit arithmetic gives count-1 / count-2 directly.
  assign top_addr = count_q[AW-1:0] - AW'(1);
  assign sec_addr = count_q[AW-1:0] - AW'(2);
  assign has_two  = (count_q >= TWO);

  rpn_stack_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .swap     (swap_do),
    .top_addr (top_addr),
    .sec_addr (sec_addr),
    .top_data (top_rd),
    .sec_data (sec_rd)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    borrow_d = borrow_q;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    we       = 1'b0;
    swap_do  = 1'b0;
    waddr    = count_q[AW-1:0];
    wdata    = push_data;

    case (state_q)
      IDLE: begin
        // exec beats swap beats push; anything lower in priority is dropped.
        if (exec) begin
          if (has_two) begin
            op_a_d  = sec_rd;
            op_b_d  = top_rd;
            state_d = EXEC;
          end else begin
            set_unf = 1'b1;
          end
        end else if (swap_req) begin
          if (has_two) swap_do = 1'b1;
          else         set_unf = 1'b1;
        end else if (push) begin
          if (count_q != FULL) begin
            we      = 1'b1;
            count_d = count_q + ONE;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      EXEC: state_d = WB;
      WB: begin
        we       = 1'b1;
        waddr    = sec_addr;
        wdata    = alu_diff;
        count_d  = count_q - ONE;
        borrow_d = alu_bo;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ovf_d = clear_err ? 1'b0 : (ovf_q | set_ovf);
    unf_d = clear_err ? 1'b0 : (unf_q | set_unf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign op_a          = op_a_q;
  assign op_b          = op_b_q;
  assign op_bi         = 1'b0;
  assign top           = (count_q == '0) ? '0 : top_rd;
  assign count         = count_q;
  assign busy          = (state_q != IDLE);
  assign borrow_flag   = borrow_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// Bench for rpn_operand_stack: directed vector table, hand sequences, and random ops vs a queue model.
module tb_rpn_operand_stack;

  logic       clk = 1'b0;
  logic       rst, push, exec, clear_err;
  logic [7:0] push_data;
  logic [7:0] alu_diff, op_a, op_b, top;
  logic       alu_bo, op_bi, busy, borrow_flag, err_overflow, err_underflow;
  logic [2:0] count;
`ifdef RPN_OPERAND_STACK_SWAP_EN
  logic       swap;
`endif

  always #5 clk = ~clk;

  // External ripple subtractor: combinational A - B - 0.
  assign alu_diff = op_a - op_b;
  assign alu_bo   = (op_a < op_b);

  rpn_operand_stack dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .push_data     (push_data),
    .exec          (exec),
`ifdef RPN_OPERAND_STACK_SWAP_EN
    .swap          (swap),
`endif
    .clear_err     (clear_err),
    .alu_diff      (alu_diff),
    .alu_bo        (alu_bo),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_bi         (op_bi),
    .top           (top),
    .count         (count),
    .busy          (busy),
    .borrow_flag   (borrow_flag),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    step();
    push = 1'b0;
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
  endtask

  // exec strobe, optionally with a same-cycle push and pushes held through EXEC/WB.
  task automatic do_exec(input bit sim_push, input bit busy_push, input logic [7:0] pd,
                         output bit busy_seen, output logic [7:0] a_seen, output logic [7:0] b_seen);
    exec = 1'b1;
    push = sim_push;
    push_data = pd;
    step();
    exec = 1'b0;
    push = busy_push;
    busy_seen = busy;
    a_seen = op_a;
    b_seen = op_b;
    step();
    step();
    push = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [7:0] et, input int ec,
                             input bit eb, input bit eo, input bit eu);
    check({tag, "_top"}, int'(top), int'(et));
    check({tag, "_count"}, int'(count), ec);
    check({tag, "_borrow"}, int'(borrow_flag), int'(eb));
    check({tag, "_ovf"}, int'(err_overflow), int'(eo));
    check({tag, "_unf"}, int'(err_underflow), int'(eu));
  endtask

  typedef struct {
    int         kind;   // 0 push, 1 exec, 2 clear_err, 3 reset
    logic [7:0] data;
    bit         pb;     // exec only: push held alongside and during busy
    logic [7:0] e_top;
    int         e_cnt;
    bit         e_bor, e_ovf, e_unf, e_busy;
    logic [7:0] e_a, e_b;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int k, input logic [7:0] d, input bit pb,
                              input logic [7:0] et, input int ec, input bit eb, input bit eo,
                              input bit eu, input bit ebusy, input logic [7:0] ea, input logic [7:0] ebb);
    vec_t v;
    v.kind = k; v.data = d; v.pb = pb; v.e_top = et; v.e_cnt = ec;
    v.e_bor = eb; v.e_ovf = eo; v.e_unf = eu; v.e_busy = ebusy; v.e_a = ea; v.e_b = ebb;
    tbl.push_back(v);
  endfunction

  // Reference model: a plain queue of stack values plus flags.
  int q[$];
  bit m_bor, m_ovf, m_unf;

  function automatic logic [7:0] m_top();
    return (q.size() == 0) ? 8'h00 : 8'(q[$]);
  endfunction

  initial begin
    bit busy_seen;
    logic [7:0] a_seen, b_seen;

    rst = 1'b1; push = 1'b0; exec = 1'b0; clear_err = 1'b0; push_data = 8'h00;
`ifdef RPN_OPERAND_STACK_SWAP_EN
    swap = 1'b0;
`endif
    #12;
    rst = 1'b0;
    #1;
    check("op_bi_const", int'(op_bi), 0);
    check("reset_busy", int'(busy), 0);

    // kind data pb  top cnt bor ovf unf busy a b
    add(3, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h05, 0, 8'h05, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h03, 0, 8'h03, 2, 0, 0, 0, 0, 8'h00, 8'h00);
    add(1, 8'h00, 0, 8'h02, 1, 0, 0, 0, 1, 8'h05, 8'h03);
    add(3, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h03, 0, 8'h03, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h05, 0, 8'h05, 2, 0, 0, 0, 0, 8'h00, 8'h00);
    add(1, 8'h00, 0, 8'hFE, 1, 1, 0, 0, 1, 8'h03, 8'h05);
    add(3, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h11, 0, 8'h11, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h22, 0, 8'h22, 2, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h33, 0, 8'h33, 3, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h44, 0, 8'h44, 4, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h55, 0, 8'h44, 4, 0, 1, 0, 0, 8'h00, 8'h00);
    add(2, 8'h00, 0, 8'h44, 4, 0, 0, 0, 0, 8'h00, 8'h00);
    add(3, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h09, 0, 8'h09, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    add(1, 8'h00, 0, 8'h09, 1, 0, 0, 1, 0, 8'h00, 8'h00);
    add(0, 8'h02, 0, 8'h02, 2, 0, 0, 1, 0, 8'h00, 8'h00);
    add(1, 8'hAA, 1, 8'h07, 1, 0, 0, 1, 1, 8'h09, 8'h02);
    add(2, 8'h00, 0, 8'h07, 1, 0, 0, 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      case (tbl[i].kind)
        0: do_push(tbl[i].data);
        1: begin
          do_exec(tbl[i].pb, tbl[i].pb, tbl[i].data, busy_seen, a_seen, b_seen);
          check({tag, "_busy"}, int'(busy_seen), int'(tbl[i].e_busy));
          if (tbl[i].e_busy) begin
            check({tag, "_op_a"}, int'(a_seen), int'(tbl[i].e_a));
            check({tag, "_op_b"}, int'(b_seen), int'(tbl[i].e_b));
          end
        end
        2: do_clear();
        default: do_reset();
      endcase
      check_state(tag, tbl[i].e_top, tbl[i].e_cnt, tbl[i].e_bor, tbl[i].e_ovf, tbl[i].e_unf);
      $display("vec %0d kind=%0d data=0x%02h -> top=0x%02h count=%0d bo=%0d ovf=%0d unf=%0d",
               i, tbl[i].kind, tbl[i].data, top, count, borrow_flag, err_overflow, err_underflow);
    end

    // clear_err beats a same-cycle overflow / underflow
    do_reset();
    for (int i = 0; i < 4; i++) do_push(8'(i + 1));
    push = 1'b1; push_data = 8'h77; clear_err = 1'b1;
    step();
    push = 1'b0; clear_err = 1'b0;
    check_state("clrprio_ovf", 8'h04, 4, 0, 0, 0);
    do_reset();
    exec = 1'b1; clear_err = 1'b1;
    step();
    exec = 1'b0; clear_err = 1'b0;
    check_state("clrprio_unf", 8'h00, 0, 0, 0, 0);
    $display("seq clear-priority done");

    // asynchronous reset while EXEC is in flight
    do_reset();
    do_push(8'h10);
    do_push(8'h01);
    exec = 1'b1;
    step();
    exec = 1'b0;
    check("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_top", int'(top), 0);
    check("abort_count", int'(count), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_op_a", int'(op_a), 0);
    check("abort_op_b", int'(op_b), 0);
    #1;
    rst = 1'b0;
    step();
    step();
    check("abort_no_wb_count", int'(count), 0);
    do_push(8'h07);
    check_state("abort_push", 8'h07, 1, 0, 0, 0);
    $display("seq async-reset abort: top=0x%02h count=%0d", top, count);

`ifdef RPN_OPERAND_STACK_SWAP_EN
    do_reset();
    do_push(8'h02);
    swap = 1'b1;
    step();
    swap = 1'b0;
    check_state("swap_unf", 8'h02, 1, 0, 0, 1);
    do_clear();
    do_push(8'h08);
    swap = 1'b1; push = 1'b1; push_data = 8'h99;
    step();
    swap = 1'b0; push = 1'b0;
    check_state("swap_xchg", 8'h02, 2, 0, 0, 0);
    do_exec(0, 0, 8'h00, busy_seen, a_seen, b_seen);
    check("swap_op_a", int'(a_seen), 8'h08);
    check_state("swap_exec", 8'h06, 1, 0, 0, 0);
    $display("seq swap: top=0x%02h count=%0d", top, count);
`endif

    // Randomized operations against the queue model
    do_reset();
    q.delete();
    m_bor = 0; m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [7:0] d;
      string tag;
      r = int'($urandom_range(0, 99));
      d = 8'($urandom);
      tag = $sformatf("rnd%0d", n);
      if (r < 45) begin
        do_push(d);
        if (q.size() < 4) q.push_back(int'(d));
        else m_ovf = 1;
        $display("rnd %0d push 0x%02h -> top=0x%02h count=%0d", n, d, top, count);
      end else if (r < 85) begin
        bit sp, bp, valid;
        int a, b;
        valid = (q.size() >= 2);
        sp = 1'($urandom);
        bp = valid && 1'($urandom);
        do_exec(sp, bp, d, busy_seen, a_seen, b_seen);
        check({tag, "_busy"}, int'(busy_seen), int'(valid));
        if (valid) begin
          b = q.pop_back();
          a = q.pop_back();
          check({tag, "_op_a"}, int'(a_seen), a);
          check({tag, "_op_b"}, int'(b_seen), b);
          q.push_back((a - b) & 8'hFF);
          m_bor = (a < b);
        end else begin
          m_unf = 1;
        end
        $display("rnd %0d exec push=%0d/%0d -> top=0x%02h count=%0d bo=%0d", n, sp, bp, top, count, borrow_flag);
      end else begin
        do_clear();
        m_ovf = 0;
        m_unf = 0;
        $display("rnd %0d clear_err -> ovf=%0d unf=%0d", n, err_overflow, err_underflow);
      end
      check_state(tag, m_top(), q.size(), m_bor, m_ovf, m_unf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rpn_operand_stack.md
Name: rpn_operand_stack

Overview:
Operand stack and sequencer for the 8-bit RPN ALU, sitting directly upstream of the 8-bit ripple full subtractor.
- Operands are pushed in RPN order.
- An execute request pops the top two entries and drives them, registered, onto the subtractor inputs.
- The returned difference is written back as the new top, and the borrow-out is latched as a status flag.

Parameters:
WIDTH, 8, data width of each stack entry and of the subtractor operands
DEPTH, 4, number of stack entries (power of two, at least 2)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  push request, one-cycle strobe
push_data  input  WIDTH  value to push
exec  input  1  execute-subtract request, one-cycle strobe
clear_err  input  1  clears sticky error flags
alu_diff  input  WIDTH  Diff returned by the subtractor
alu_bo  input  1  Bo returned by the subtractor
op_a  output  WIDTH  subtractor A, the minuend (second-from-top entry)
op_b  output  WIDTH  subtractor B, the subtrahend (top entry)
op_bi  output  1  subtractor Bi, tied to 0
top  output  WIDTH  current top of stack, 0 when empty
count  output  clog2(DEPTH)+1  number of valid entries
busy  output  1  high while an execute is in flight
borrow_flag  output  1  Bo of the last completed execute
err_overflow  output  1  sticky: push attempted while full
err_underflow  output  1  sticky: exec attempted with count<2

Behaviour:
Reset (asynchronous, effective immediately on rst=1):
- All outputs are 0; all entries are cleared; the FSM returns to IDLE.
- Reset mid-execute aborts the execute with no writeback.

FSM states:
- IDLE
  - exec=1 with count>=2: register op_a=entry[count-2] and op_b=entry[count-1], go to EXEC.
  - exec=1 with count<2: set err_underflow, stay in IDLE, stack unchanged.
- EXEC
  - busy=1.
  - Operands are held stable for the full cycle; the subtractor is combinational.
  - Go to WB.
- WB
  - busy=1.
  - entry[count-2] <= alu_diff; count <= count-1; borrow_flag <= alu_bo.
  - Go to IDLE.

Timing:
- Latency from exec to the updated top/count is 3 clock edges (IDLE→EXEC→WB→IDLE).
- A new exec can be accepted on the cycle after WB.

Push rules:
- Accepted only in IDLE when exec=0.
- count<DEPTH: entry[count] <= push_data; count increments; top updates on the next cycle.
- count==DEPTH: set err_overflow, stack unchanged.
- Push during busy is silently dropped, with no error.
- Push and exec in the same IDLE cycle: exec wins and the push is dropped.

Arithmetic:
- Result is (A - B) mod 2^WIDTH.
- alu_bo=1 means A<B, unsigned.

Outputs and errors:
- op_a and op_b hold their last values outside EXEC.
- op_bi is constant 0.
- clear_err clears both error flags on the next edge. It has priority over a same-cycle error set, so the flag ends up clear.

Optional Feature:
RPN_OPERAND_STACK_SWAP_EN
- Defined: adds input port swap (1-bit strobe).
  - In IDLE with count>=2, swap exchanges entry[count-1] and entry[count-2] in one cycle.
  - With count<2 it sets err_underflow.
  - Priority order: exec, then swap, then push.
  - Ignored while busy.
- Undefined: the swap port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rpn_pkg holds:
  - WIDTH and DEPTH defaults
  - FSM state typedef (IDLE, EXEC, WB; 2-bit encoding)
  - count-width constant
- One sub-module, rpn_stack_regfile:
  - DEPTH×WIDTH register array with async clear
  - one write port and two read ports (top, second)
- The FSM and counter stay in the top module.

Test Plan:
1. push 0x05, push 0x03, exec → op_a=0x05, op_b=0x03 during EXEC; after WB, top=0x02, count=1, borrow_flag=0.
2. push 0x03, push 0x05, exec → top=0xFE, count=1, borrow_flag=1.
3. push 0x11,0x22,0x33,0x44,0x55 → count=4, top=0x44, err_overflow=1; then clear_err → err_overflow=0.
4. push 0x09, exec → err_underflow=1, count=1, top=0x09, busy never asserted; push during busy is dropped (count unchanged by it).
5. push 0x10, push 0x01, exec, assert rst during EXEC → all outputs 0 and count=0 asynchronously; a subsequent push 0x07 gives top=0x07.
6. With RPN_OPERAND_STACK_SWAP_EN: push 0x02, push 0x08, swap, exec → top=0x06, borrow_flag=0.
